seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 16'd100, cycles that sel and seg must hold unchanged before a digit is captured.
REQ-002 Parameter TIMEOUT, default 20'd600_000, cycles without any capture before the partial frame is discarded.
REQ-003 sys_clk  input  1  single system clock; all state on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 seg  input  8  multiplexed segment bus, active-low; seg[7] = decimal point, seg[6:0] = g..a.
REQ-006 sel  input  6  digit select, one-hot active-high; bit0 = unit .. bit5 = h_tho.
REQ-007 unit, ten, hun, tho, t_tho, h_tho  output  4 each  decoded BCD digits, registered.
REQ-008 point  output  6  decoded dot mask; point[i] = 1 when digit i dot lit.
REQ-009 frame_valid  output  1  one-cycle pulse when all six digit outputs and point are updated.
REQ-010 code_err  output  1  one-cycle pulse with frame_valid when any digit in that frame was undecodable.
REQ-011 scan_lost  output  1  one-cycle pulse when TIMEOUT expires.

Function
REQ-012 Input sampling: seg and sel registered once before any use; all comparisons on registered copies.
REQ-013 FSM states WAIT, SETTLE, HOLD; reset state WAIT.
REQ-014 WAIT: sel one-hot -> SETTLE, stable counter cleared; sel zero or multi-hot -> stay WAIT.
REQ-015 SETTLE: sel or seg differs from previous sample -> counter cleared, stay SETTLE (or WAIT if sel no longer one-hot); counter reaching STABLE_CYC-1 -> capture, go HOLD.
REQ-016 HOLD: no further capture; any sel change -> WAIT rules applied same cycle; seg change alone ignored.
REQ-017 Capture decode (seg[6:0]): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9; any other pattern -> 4'hF and frame error flag set.
REQ-018 Capture writes shadow digit and shadow dot (~seg[7]) at index of sel bit, sets mask bit; repeat capture of same index overwrites shadow.
REQ-019 Capture that makes mask 6'h3F: next cycle copy all shadows to outputs atomically, pulse frame_valid, pulse code_err if frame error flag set, clear mask and error flag.
REQ-020 Outputs change only on frame completion; partial frames never visible.
REQ-021 Timeout counter clears on every capture, increments otherwise; reaching TIMEOUT-1 -> pulse scan_lost, clear mask and error flag, counter restarts from 0; outputs retain last frame.
REQ-022 Capture and timeout in same cycle: capture wins, no scan_lost.
REQ-023 Counters saturate-free: stable counter 16 bits, timeout counter 20 bits; no wrap beyond parameter limits.

Reset
REQ-024 sys_rst_n low: all digits 4'd0, point 6'd0, frame_valid/code_err/scan_lost 0, mask 0, counters 0, FSM WAIT, within same cycle, independent of clock.
REQ-025 Reset mid-frame discards shadow contents; first frame_valid after release requires six fresh captures.

Verification
REQ-026 Scan 6 digits "123456" (unit=6 .. h_tho=1), 500 cycles per digit, STABLE_CYC=100 -> one frame_valid after sixth capture, outputs 6,5,4,3,2,1, point 0, code_err 0.
REQ-027 Same scan with seg[7]=0 on sel=6'b000100 -> point = 6'b000100 at frame_valid.
REQ-028 sel dwell 50 cycles, STABLE_CYC=100 -> no capture, no frame_valid; scan_lost at cycle TIMEOUT after last capture.
REQ-029 seg = 8'hFF on digit 3 -> tho = 4'hF, code_err pulses with frame_valid.
REQ-030 sel = 6'b000011 for 1000 cycles -> no capture; sel = 6'b000000 likewise.
REQ-031 Assert sys_rst_n low after 4 captures, release, scan 2 digits -> no frame_valid; full 6 more -> frame_valid with fresh values.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Recovers the six BCD digits and dot mask shown on a multiplexed, active-low
// 7-segment display by watching its segment and digit-select buses.
module seg_scan_decoder #(
    parameter logic [15:0] STABLE_CYC = 16'd100,
    parameter logic [19:0] TIMEOUT    = 20'd600_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] seg,
    input  logic [5:0] sel,
    output logic [3:0] unit,
    output logic [3:0] ten,
    output logic [3:0] hun,
    output logic [3:0] tho,
    output logic [3:0] t_tho,
    output logic [3:0] h_tho,
    output logic [5:0] point,
    output logic       frame_valid,
    output logic       code_err,
    output logic       scan_lost
);

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_stb_cnt;
    logic [15:0] w_stb_next;
    logic [19:0] r_to_cnt;
    logic [7:0]  r_seg;
    logic [7:0]  r_seg_d;
    logic [5:0]  r_sel;
    logic [5:0]  r_sel_d;
    logic [5:0]  r_mask;
    logic        r_frame_err;
    logic        r_commit;
    logic        r_commit_err;
    logic        r_frame_valid;
    logic        r_code_err;
    logic        r_scan_lost;

    logic [5:0][3:0] r_shadow;
    logic [5:0]      r_shadow_dp;
    logic [5:0][3:0] r_out_digit;
    logic [5:0]      r_point;

    logic       w_onehot;
    logic       w_sel_chg;
    logic       w_seg_chg;
    logic       w_capture;
    logic [3:0] w_dec;
    logic       w_bad;
    logic       w_mask_full;

    // Two sample stages: the first isolates the pins, the second is the
    // "previous sample" that stability is judged against.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_seg   <= 8'd0;
            r_seg_d <= 8'd0;
            r_sel   <= 6'd0;
            r_sel_d <= 6'd0;
        end else begin
            r_seg   <= seg;
            r_seg_d <= r_seg;
            r_sel   <= sel;
            r_sel_d <= r_sel;
        end
    end

    assign w_onehot    = (r_sel != 6'd0) && ((r_sel & (r_sel - 6'd1)) == 6'd0);
    assign w_sel_chg   = (r_sel != r_sel_d);
    assign w_seg_chg   = (r_seg != r_seg_d);
    assign w_mask_full = ((r_mask | r_sel) == 6'h3F);

    always_comb begin
        w_state_next = r_state;
        w_stb_next   = r_stb_cnt;
        w_capture    = 1'b0;
        case (r_state)
            WAIT: begin
                if (w_onehot) begin
                    w_state_next = SETTLE;
                    w_stb_next   = 16'd0;
                end
            end
            SETTLE: begin
                if (w_sel_chg || w_seg_chg) begin
                    w_stb_next   = 16'd0;
                    w_state_next = w_onehot ? SETTLE : WAIT;
                end else if (r_stb_cnt == STABLE_CYC - 16'd1) begin
                    w_capture    = 1'b1;
                    w_stb_next   = 16'd0;
                    w_state_next = HOLD;
                end else begin
                    w_stb_next = r_stb_cnt + 16'd1;
                end
            end
            HOLD: begin
                // Segment flicker on an already captured digit is ignored.
                if (w_sel_chg) begin
                    w_stb_next   = 16'd0;
                    w_state_next = w_onehot ? SETTLE : WAIT;
                end
            end
            default: w_state_next = WAIT;
        endcase
    end

    always_comb begin
        w_bad = 1'b0;
        case (r_seg[6:0])
            7'b1000000: w_dec = 4'd0;
            7'b1111001: w_dec = 4'd1;
            7'b0100100: w_dec = 4'd2;
            7'b0110000: w_dec = 4'd3;
            7'b0011001: w_dec = 4'd4;
            7'b0010010: w_dec = 4'd5;
            7'b0000010: w_dec = 4'd6;
            7'b1111000: w_dec = 4'd7;
            7'b0000000: w_dec = 4'd8;
            7'b0010000: w_dec = 4'd9;
            default: begin
                w_dec = 4'hF;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= WAIT;
            r_stb_cnt     <= 16'd0;
            r_to_cnt      <= 20'd0;
            r_mask        <= 6'd0;
            r_frame_err   <= 1'b0;
            r_commit      <= 1'b0;
            r_commit_err  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_code_err    <= 1'b0;
            r_scan_lost   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_stb_cnt     <= w_stb_next;
            r_commit      <= 1'b0;
            r_frame_valid <= r_commit;
            r_code_err    <= r_commit & r_commit_err;
            r_scan_lost   <= 1'b0;
            // A capture always beats a simultaneous timeout.
            if (w_capture) begin
                r_to_cnt <= 20'd0;
                if (w_mask_full) begin
                    r_mask       <= 6'd0;
                    r_frame_err  <= 1'b0;
                    r_commit     <= 1'b1;
                    r_commit_err <= r_frame_err | w_bad;
                end else begin
                    r_mask      <= r_mask | r_sel;
                    r_frame_err <= r_frame_err | w_bad;
                end
            end else if (r_to_cnt == TIMEOUT - 20'd1) begin
                r_to_cnt    <= 20'd0;
                r_scan_lost <= 1'b1;
                r_mask      <= 6'd0;
                r_frame_err <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + 20'd1;
            end
        end
    end

    // Per-digit shadow and output registers; outputs only move on commit so a
    // partial frame is never visible.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_shadow[gi]    <= 4'd0;
                    r_shadow_dp[gi] <= 1'b0;
                    r_out_digit[gi] <= 4'd0;
                    r_point[gi]     <= 1'b0;
                end else begin
                    if (w_capture && r_sel[gi]) begin
                        r_shadow[gi]    <= w_dec;
                        r_shadow_dp[gi] <= ~r_seg[7];
                    end
                    if (r_commit) begin
                        r_out_digit[gi] <= r_shadow[gi];
                        r_point[gi]     <= r_shadow_dp[gi];
                    end
                end
            end
        end
    endgenerate

    assign unit        = r_out_digit[0];
    assign ten         = r_out_digit[1];
    assign hun         = r_out_digit[2];
    assign tho         = r_out_digit[3];
    assign t_tho       = r_out_digit[4];
    assign h_tho       = r_out_digit[5];
    assign point       = r_point;
    assign frame_valid = r_frame_valid;
    assign code_err    = r_code_err;
    assign scan_lost   = r_scan_lost;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full display frames plus
// hand-written timeout, multi-hot select and mid-frame reset sequences.
module tb_seg_scan_decoder;

    localparam logic [15:0] STB   = 16'd100;
    localparam logic [19:0] TMO   = 20'd3000;
    localparam int          DWELL = 500;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] seg;
    logic [5:0] sel;
    logic [3:0] unit, ten, hun, tho, t_tho, h_tho;
    logic [5:0] point;
    logic       frame_valid, code_err, scan_lost;

    seg_scan_decoder #(.STABLE_CYC(STB), .TIMEOUT(TMO)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .seg(seg), .sel(sel),
        .unit(unit), .ten(ten), .hun(hun), .tho(tho), .t_tho(t_tho), .h_tho(h_tho),
        .point(point), .frame_valid(frame_valid), .code_err(code_err), .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [5:0][7:0] segs;   // index 0 = unit
        logic [5:0][3:0] digs;
        logic [5:0]      pt;
        logic            err;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0, sl_cnt = 0, stray_err = 0;
    int fv_cyc = 0, sl_cyc = 0;
    logic [5:0][3:0] snap_d;
    logic [5:0]      snap_pt;
    logic            snap_err;
    logic [5:0][3:0] exp_d;
    logic [5:0]      exp_pt;

    function automatic vec_t mk(input string n, input logic [5:0][7:0] s,
                                input logic [5:0][3:0] d, input logic [5:0] p, input logic e);
        vec_t v;
        v.name = n; v.segs = s; v.digs = d; v.pt = p; v.err = e;
        return v;
    endfunction

    function automatic logic [23:0] outs();
        return {h_tho, t_tho, tho, hun, ten, unit};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (frame_valid) begin
            fv_cnt++;
            fv_cyc   = cyc;
            snap_d   = outs();
            snap_pt  = point;
            snap_err = code_err;
        end
        if (scan_lost) begin
            sl_cnt++;
            sl_cyc = cyc;
        end
        if (code_err && !frame_valid) stray_err++;
    endtask

    task automatic hold(input logic [5:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) step();
    endtask

    task automatic scan(input logic [5:0][7:0] segs, input int first, input int last);
        for (int i = first; i <= last; i++) hold(6'(1 << i), segs[i], DWELL);
    endtask

    // Alternate between two selects every 50 cycles: too short to capture.
    task automatic toggle(input logic [5:0] a, input logic [5:0] b, input int n);
        for (int k = 0; k < n / 50; k++) hold((k % 2 == 1) ? b : a, 8'hC0, 50);
    endtask

    initial begin
        vecs[0] = mk("123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82},
                     {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 6'b000000, 1'b0);
        vecs[1] = mk("dot_hun", {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82},
                     {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, 6'b000100, 1'b0);
        vecs[2] = mk("bad_tho", {8'hF9, 8'hA4, 8'hFF, 8'h99, 8'h92, 8'h82},
                     {4'd1, 4'd2, 4'hF, 4'd4, 4'd5, 4'd6}, 6'b000000, 1'b1);
        vecs[3] = mk("307890", {8'h30, 8'h40, 8'h90, 8'h80, 8'hF8, 8'hC0},
                     {4'd3, 4'd0, 4'd9, 4'd8, 4'd7, 4'd0}, 6'b110000, 1'b0);
        vecs[4] = mk("bad_low", {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h81, 8'h7F},
                     {4'd4, 4'd3, 4'd2, 4'd1, 4'hF, 4'hF}, 6'b000001, 1'b1);

        rst_n = 1'b0;
        sel   = 6'd0;
        seg   = 8'hFF;
        repeat (3) step();
        chk("rst_digits", 32'(outs()), 32'd0);
        chk("rst_point", 32'(point), 32'd0);
        chk("rst_flags", 32'({frame_valid, code_err, scan_lost}), 32'd0);
        rst_n = 1'b1;
        exp_d  = '0;
        exp_pt = '0;

        for (int v = 0; v < 5; v++) begin
            fv_cnt = 0;
            sl_cnt = 0;
            scan(vecs[v].segs, 0, 4);
            chk("partial_fv", 32'(fv_cnt), 32'd0);
            chk("partial_hold", 32'(outs()), 32'(exp_d));
            scan(vecs[v].segs, 5, 5);
            chk("frame_fv", 32'(fv_cnt), 32'd1);
            chk("frame_digits", 32'(snap_d), 32'(vecs[v].digs));
            chk("frame_point", 32'(snap_pt), 32'(vecs[v].pt));
            chk("frame_code_err", 32'(snap_err), 32'(vecs[v].err));
            chk("frame_retain", 32'(outs()), 32'(vecs[v].digs));
            chk("frame_no_lost", 32'(sl_cnt), 32'd0);
            exp_d  = vecs[v].digs;
            exp_pt = vecs[v].pt;
            $display("frame %s: digits %h point %b code_err %b", vecs[v].name, snap_d, snap_pt, snap_err);
        end

        // Short dwells never capture: scan_lost lands TMO cycles after the last
        // capture, which is one cycle before the frame_valid that followed it.
        fv_cnt = 0;
        sl_cnt = 0;
        toggle(6'b000001, 6'b000010, int'(TMO));
        chk("dwell_fv", 32'(fv_cnt), 32'd0);
        chk("dwell_lost_cnt", 32'(sl_cnt), 32'd1);
        chk("dwell_lost_time", 32'(sl_cyc - fv_cyc), 32'(TMO) - 32'd1);
        chk("lost_retain", 32'(outs()), 32'(exp_d));
        chk("lost_retain_pt", 32'(point), 32'(exp_pt));
        $display("timeout: scan_lost %0d cycles after frame_valid", sl_cyc - fv_cyc);

        // Timeout discards a partial frame including its error flag.
        fv_cnt = 0;
        sl_cnt = 0;
        hold(6'b000001, 8'hFF, DWELL);
        hold(6'b000010, 8'h92, DWELL);
        hold(6'b000100, 8'h99, DWELL);
        toggle(6'b001000, 6'b010000, int'(TMO));
        chk("discard_lost", 32'(sl_cnt), 32'd1);
        scan(vecs[0].segs, 3, 5);
        chk("discard_fv", 32'(fv_cnt), 32'd0);
        scan(vecs[3].segs, 0, 2);
        chk("mixed_fv", 32'(fv_cnt), 32'd1);
        chk("mixed_digits", 32'(snap_d), 32'h123870);
        chk("mixed_point", 32'(snap_pt), 32'd0);
        chk("mixed_code_err", 32'(snap_err), 32'd0);
        $display("frame after timeout: digits %h code_err %b", snap_d, snap_err);

        // Multi-hot and idle select never capture.
        fv_cnt = 0;
        sl_cnt = 0;
        scan(vecs[0].segs, 0, 4);
        hold(6'b000011, 8'hC0, 1000);
        hold(6'b000000, 8'hC0, 1000);
        chk("multihot_fv", 32'(fv_cnt), 32'd0);
        chk("multihot_lost", 32'(sl_cnt), 32'd0);
        hold(6'b100000, 8'hF9, DWELL);
        chk("multihot_frame_fv", 32'(fv_cnt), 32'd1);
        chk("multihot_digits", 32'(snap_d), 32'(vecs[0].digs));
        $display("frame after multi-hot: digits %h", snap_d);

        // Mid-frame reset clears outputs at once and discards captures.
        scan(vecs[4].segs, 0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_digits", 32'(outs()), 32'd0);
        chk("async_rst_point", 32'(point), 32'd0);
        chk("async_rst_flags", 32'({frame_valid, code_err, scan_lost}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        fv_cnt = 0;
        scan(vecs[3].segs, 4, 5);
        chk("post_rst_fv", 32'(fv_cnt), 32'd0);
        chk("post_rst_hidden", 32'(outs()), 32'd0);
        scan(vecs[3].segs, 0, 5);
        chk("post_rst_frame_fv", 32'(fv_cnt), 32'd1);
        chk("post_rst_digits", 32'(snap_d), 32'(vecs[3].digs));
        chk("post_rst_point", 32'(snap_pt), 32'(vecs[3].pt));
        $display("frame after reset: digits %h point %b", snap_d, snap_pt);

        chk("stray_code_err", 32'(stray_err), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
